// File: rtl/softex_lane_gather.sv
// softex_lane_gather: collects the narrow per-lane result streams of the softex
// datapath into one wide stream. This undoes the strided element split made on
// the input side. Each lane has a small elastic FIFO. A wide beat is built only
// when every lane holds a beat, and all lanes pop together.
module softex_lane_gather #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned LANE_DW    = 64,
  parameter int unsigned EW         = 16,
  parameter int unsigned ES         = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic [NUM_LANES-1:0]                  lane_valid_i,
  input  logic [NUM_LANES-1:0][LANE_DW-1:0]     lane_data_i,
  input  logic [NUM_LANES-1:0][LANE_DW/8-1:0]   lane_strb_i,
  output logic [NUM_LANES-1:0]                  lane_ready_o,
  output logic                                  out_valid_o,
  output logic [NUM_LANES*LANE_DW-1:0]          out_data_o,
  output logic [NUM_LANES*LANE_DW/8-1:0]        out_strb_o,
  input  logic                                  out_ready_i,
  output logic [CNT_W-1:0]                      beat_cnt_o,
  output logic                                  desync_o
);

  localparam int unsigned SW  = LANE_DW / 8;          // strobe bits per lane
  localparam int unsigned GW  = EW * ES;              // bits per group
  localparam int unsigned GB  = GW / 8;               // strobe bits per group
  localparam int unsigned CPL = LANE_DW / GW;         // groups (chunks) per lane
  localparam int unsigned G   = NUM_LANES * CPL;      // groups per wide word
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  logic [NUM_LANES-1:0]         full;
  logic [NUM_LANES-1:0]         empty;
  logic [NUM_LANES-1:0]         push;
  logic [LANE_DW-1:0]           head_data [NUM_LANES];
  logic [SW-1:0]                head_strb [NUM_LANES];
  logic [NUM_LANES*LANE_DW-1:0] gather_data;
  logic [NUM_LANES*SW-1:0]      gather_strb;
  logic                         gather;
  logic                         fire;

  // Circular pointer advance; the depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // A wide beat forms only when every lane has data and the output slot is free or draining.
  assign gather       = (&(~empty)) & (~out_valid_o | out_ready_i);
  assign fire         = out_valid_o & out_ready_i;
  // Ready depends only on the registered fill level, so it never follows valid or out_ready.
  assign lane_ready_o = ~full;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_DW-1:0] mem_data [FIFO_DEPTH];
    logic [SW-1:0]      mem_strb [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    assign full[l]      = (count == CW'(FIFO_DEPTH));
    assign empty[l]     = (count == '0);
    assign push[l]      = lane_valid_i[l] & ~full[l] & ~clear_i;
    assign head_data[l] = mem_data[rd_ptr];
    assign head_strb[l] = mem_strb[rd_ptr];

    // Lane FIFO storage write; the contents need no reset because count guards them.
    always_ff @(posedge clk_i) begin
      if (push[l]) begin
        mem_data[wr_ptr] <= lane_data_i[l];
        mem_strb[wr_ptr] <= lane_strb_i[l];
      end
    end

    // Lane FIFO pointers and fill level; pops happen only as part of a gather.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (clear_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[l]) begin
          wr_ptr <= ptr_next(wr_ptr);
        end
        if (gather) begin
          rd_ptr <= ptr_next(rd_ptr);
        end
        count <= count + CW'(push[l]) - CW'(gather);
      end
    end
  end

  // Group g of the wide word is chunk g/NUM_LANES of lane g%NUM_LANES; this inverts the input stride.
  for (genvar g = 0; g < G; g++) begin : g_map
    assign gather_data[g*GW +: GW] = head_data[g % NUM_LANES][(g / NUM_LANES)*GW +: GW];
    assign gather_strb[g*GB +: GB] = head_strb[g % NUM_LANES][(g / NUM_LANES)*GB +: GB];
  end

  // Output register: load on gather, otherwise hold until the downstream accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_strb_o  <= '0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_strb_o  <= '0;
    end else if (gather) begin
      out_valid_o <= 1'b1;
      out_data_o  <= gather_data;
      out_strb_o  <= gather_strb;
    end else if (fire) begin
      out_valid_o <= 1'b0;
    end
  end

  // Count accepted wide beats, wrapping naturally at the counter width.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_o <= '0;
    end else if (clear_i) begin
      beat_cnt_o <= '0;
    end else if (fire) begin
      beat_cnt_o <= beat_cnt_o + CNT_W'(1);
    end
  end

  // Sticky skew flag: one lane backed up to full while another has nothing buffered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      desync_o <= 1'b0;
    end else if (clear_i) begin
      desync_o <= 1'b0;
    end else if ((|full) & (|empty)) begin
      desync_o <= 1'b1;
    end
  end

endmodule
